// File: rtl/ext_trig_pkg.sv
// Shared constants for the external trigger shaper.
// Edge-select codes and per-channel state encoding.
package ext_trig_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PULSE   = 2'b01,
        ST_HOLDOFF = 2'b10
    } chan_state_t;

endpackage

// File: rtl/ext_trig_chan.sv
// One trigger channel: synchroniser, edge detect,
// pulse/hold-off FSM with its down-counter.
module ext_trig_chan
    import ext_trig_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic             Trig,
    input  logic [1:0]       Cfg_Edge,
    input  logic [CNT_W-1:0] Cfg_Width,
    input  logic [CNT_W-1:0] Cfg_Holdoff,
    input  logic             Cfg_Retrig,
    input  logic             Mask,
    output logic             Pulse,
    output logic             Busy,
    output logic             Accept,
    output logic             Reject
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;
    logic                   hit;
    logic [CNT_W-1:0]       w_m1;

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Trig};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

    always_comb begin
        edge_det = 1'b0;
        unique case (Cfg_Edge)
            EDGE_RISE: edge_det = rise;
            EDGE_FALL: edge_det = fall;
            EDGE_BOTH: edge_det = rise | fall;
            EDGE_OFF:  edge_det = 1'b0;
            default:   edge_det = 1'b0;
        endcase
    end

    assign hit  = edge_det & ~Mask;
    // A zero width still yields a one-clock pulse.
    assign w_m1 = (Cfg_Width == '0) ? '0
                : Cfg_Width - CNT_W'(1);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_PULSE;
                    cnt_d   = w_m1;
                    hold_d  = Cfg_Holdoff;
                end
            end
            ST_PULSE: begin
                // Retrigger wins over the terminal count.
                if (hit && Cfg_Retrig) begin
                    cnt_d = w_m1;
                end else if (cnt_q == '0) begin
                    if (hold_q != '0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = hold_q - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        Accept  = 1'b0;
        Reject  = 1'b0;
        pulse_d = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE:    Accept = hit;
            ST_PULSE: begin
                Accept = hit & Cfg_Retrig;
                Reject = hit & ~Cfg_Retrig;
            end
            ST_HOLDOFF: Reject = hit;
            default:    Accept = 1'b0;
        endcase
    end

    assign Pulse = pulse_q;
    assign Busy  = busy_q;

endmodule

// File: rtl/ext_trig_shaper.sv
// Multi-channel external trigger shaper with
// saturating accepted/rejected trigger counters.
module ext_trig_shaper
    import ext_trig_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TCNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic [N_CH-1:0]   In_Trig,
    input  logic [1:0]        Cfg_Edge,
    input  logic [CNT_W-1:0]  Cfg_Width,
    input  logic [CNT_W-1:0]  Cfg_Holdoff,
    input  logic              Cfg_Retrig,
    input  logic [N_CH-1:0]   Cfg_Mask,
    input  logic              Cnt_Clr,
    output logic [N_CH-1:0]   Out_Trig,
    output logic              Out_Trig_Any,
    output logic [N_CH-1:0]   Busy,
    output logic [TCNT_W-1:0] Trig_Count,
    output logic [TCNT_W-1:0] Rej_Count
);

    localparam int PW = $clog2(N_CH + 1);
    localparam int SW = ((TCNT_W > PW) ? TCNT_W : PW) + 1;

    logic [N_CH-1:0]   pulse;
    logic [N_CH-1:0]   acc;
    logic [N_CH-1:0]   rej;
    logic [PW-1:0]     acc_pop;
    logic [PW-1:0]     rej_pop;
    logic [TCNT_W-1:0] trig_cnt_q;
    logic [TCNT_W-1:0] rej_cnt_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ext_trig_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .Clk         (Clk),
            .Rst_N       (Rst_N),
            .Trig        (In_Trig[i]),
            .Cfg_Edge    (Cfg_Edge),
            .Cfg_Width   (Cfg_Width),
            .Cfg_Holdoff (Cfg_Holdoff),
            .Cfg_Retrig  (Cfg_Retrig),
            .Mask        (Cfg_Mask[i]),
            .Pulse       (pulse[i]),
            .Busy        (Busy[i]),
            .Accept      (acc[i]),
            .Reject      (rej[i])
        );
    end

    always_comb begin
        acc_pop = '0;
        rej_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc_pop = acc_pop + PW'(acc[i]);
            rej_pop = rej_pop + PW'(rej[i]);
        end
    end

    // Clear restarts from this cycle's events; the sum saturates.
    function automatic logic [TCNT_W-1:0] sat_add(
        input logic [TCNT_W-1:0] cur,
        input logic [PW-1:0]     inc,
        input logic              clr
    );
        logic [SW-1:0] sum;
        sum = (clr ? SW'(0) : SW'(cur)) + SW'(inc);
        if (sum > SW'({TCNT_W{1'b1}})) begin
            return '1;
        end
        return sum[TCNT_W-1:0];
    endfunction

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            trig_cnt_q <= '0;
            rej_cnt_q  <= '0;
        end else begin
            trig_cnt_q <= sat_add(trig_cnt_q, acc_pop, Cnt_Clr);
            rej_cnt_q  <= sat_add(rej_cnt_q, rej_pop, Cnt_Clr);
        end
    end

    assign Out_Trig     = pulse;
    assign Out_Trig_Any = |pulse;
    assign Trig_Count   = trig_cnt_q;
    assign Rej_Count    = rej_cnt_q;

endmodule
